// File: rtl/rom_load_router.sv
// ROM download router: decodes the ioctl byte stream into address windows and
// drives one-hot ROM write strobes, tracking per-region byte counts and checksums.
module rom_load_router #(
    parameter int NUM_REGIONS = 8,
    parameter int ROM_AW = 15,
    parameter logic [NUM_REGIONS*27-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*5-1:0] REGION_AW = {NUM_REGIONS{5'd8}},
    parameter int WORD_MODE = 0
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   ioctl_download,
    input  logic [26:0]            ioctl_addr,
    input  logic [15:0]            ioctl_dout,
    input  logic                   ioctl_wr,
    output logic                   ioctl_wait,
    output logic [NUM_REGIONS-1:0] rom_wr_en,
    output logic [ROM_AW-1:0]      rom_wr_addr,
    output logic [7:0]             rom_wr_data,
    output logic [NUM_REGIONS-1:0] region_done,
    output logic                   load_done,
    output logic                   dl_err,
    input  logic [3:0]             chk_sel,
    output logic [15:0]            chk_sum
);

    localparam int CW = ROM_AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SPLIT, DONE} state_t;

    state_t                   state;
    logic                     dl_q;
    logic                     start;
    logic                     byte_valid;
    logic [27:0]              byte_addr;
    logic [7:0]               byte_data;
    logic [7:0]               hi_data;
    logic                     hit;
    logic [NUM_REGIONS-1:0]   hit_oh;
    logic [ROM_AW-1:0]        hit_off;
    logic [27:0]              dec_base;
    logic [CW-1:0]            count [NUM_REGIONS];
    logic [15:0]              sum   [NUM_REGIONS];

    function automatic logic [CW-1:0] region_size(input int i);
        return CW'(1) << REGION_AW[5*i +: 5];
    endfunction

    assign start = (state == IDLE) && ioctl_download && !dl_q;

    // Stage 1: the FSM turns each accepted ioctl_wr into one or two byte slots.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            byte_valid <= 1'b0;
            byte_addr  <= '0;
            byte_data  <= '0;
            hi_data    <= '0;
            ioctl_wait <= 1'b0;
            load_done  <= 1'b0;
            dl_err     <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            byte_valid <= 1'b0;
            ioctl_wait <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        load_done <= 1'b0;
                        dl_err    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!ioctl_download) begin
                        state <= DONE;
                    end else if (ioctl_wr) begin
                        byte_valid <= 1'b1;
                        byte_addr  <= {1'b0, ioctl_addr};
                        byte_data  <= ioctl_dout[7:0];
                        hi_data    <= ioctl_dout[15:8];
                        if (WORD_MODE != 0) state <= SPLIT;
                    end
                end
                SPLIT: begin
                    byte_valid <= 1'b1;
                    byte_addr  <= byte_addr + 28'd1;
                    byte_data  <= hi_data;
                    ioctl_wait <= 1'b1;
                    if (ioctl_wr) dl_err <= 1'b1;
                    state <= ioctl_download ? LOAD : DONE;
                end
                DONE: begin
                    state     <= IDLE;
                    load_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scanning from the top index down lets the lowest matching window win.
    always_comb begin
        hit      = 1'b0;
        hit_oh   = '0;
        dec_base = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (byte_addr >= {1'b0, REGION_BASE[27*i +: 27]} &&
                byte_addr < {1'b0, REGION_BASE[27*i +: 27]} + (28'd1 << REGION_AW[5*i +: 5])) begin
                hit      = 1'b1;
                hit_oh   = NUM_REGIONS'(1) << i;
                dec_base = {1'b0, REGION_BASE[27*i +: 27]};
            end
        end
        hit_off = ROM_AW'(byte_addr - dec_base);
    end

    // Stage 2: registered strobe plus per-region statistics on the same edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rom_wr_en   <= '0;
            rom_wr_addr <= '0;
            rom_wr_data <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                count[i] <= '0;
                sum[i]   <= '0;
            end
        end else begin
            rom_wr_en <= '0;
            if (start) begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    count[i] <= '0;
                    sum[i]   <= '0;
                end
            end else if (byte_valid && hit) begin
                rom_wr_en   <= hit_oh;
                rom_wr_addr <= hit_off;
                rom_wr_data <= byte_data;
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (hit_oh[i]) begin
                        if (count[i] != region_size(i)) count[i] <= count[i] + CW'(1);
                        sum[i] <= sum[i] + {8'd0, byte_data};
                    end
                end
            end
        end
    end

    always_comb begin
        region_done = '0;
        chk_sum     = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            region_done[i] = (count[i] == region_size(i));
            if (chk_sel == 4'(i)) chk_sum = sum[i];
        end
    end

endmodule

// File: tb/tb_rom_load_router.sv
// Bench for rom_load_router: a byte-mode and a word-mode instance share one
// stimulus stream; each scenario checks the instance it targets.
module tb_rom_load_router;

    localparam int NR = 8;
    localparam int AW = 15;
    localparam logic [NR*27-1:0] BASES = {27'h0000000, 27'h0030000, 27'h0020008, 27'h0020000,
                                          27'h0048100, 27'h0048000, 27'h0014000, 27'h0068000};
    localparam logic [NR*5-1:0]  AWS   = {5'd1, 5'd15, 5'd4, 5'd4, 5'd8, 5'd8, 5'd8, 5'd8};

    int m_base[NR] = '{32'h68000, 32'h14000, 32'h48000, 32'h48100, 32'h20000, 32'h20008, 32'h30000, 32'h0};
    int m_aw[NR]   = '{8, 8, 8, 8, 4, 4, 15, 1};
    int m_cnt[NR];
    int m_sum[NR];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        download = 1'b0;
    logic        wr = 1'b0;
    logic [26:0] addr = '0;
    logic [15:0] dout = '0;
    logic [3:0]  chk_sel = '0;

    logic           b_wait, b_load, b_err, w_wait, w_load, w_err;
    logic [NR-1:0]  b_en, b_done, w_en, w_done;
    logic [AW-1:0]  b_addr, w_addr;
    logic [7:0]     b_data, w_data;
    logic [15:0]    b_sum, w_sum;

    int tests_run = 0;
    int tests_failed = 0;

    bit          s_valid[512];
    bit          s_wait[512];
    longint      s_addr[512];
    logic [7:0]  s_data[512];

    rom_load_router #(.NUM_REGIONS(NR), .ROM_AW(AW), .REGION_BASE(BASES), .REGION_AW(AWS), .WORD_MODE(0)) u_byte (
        .clk_sys(clk), .rst_n(rst_n), .ioctl_download(download), .ioctl_addr(addr), .ioctl_dout(dout),
        .ioctl_wr(wr), .ioctl_wait(b_wait), .rom_wr_en(b_en), .rom_wr_addr(b_addr), .rom_wr_data(b_data),
        .region_done(b_done), .load_done(b_load), .dl_err(b_err), .chk_sel(chk_sel), .chk_sum(b_sum));

    rom_load_router #(.NUM_REGIONS(NR), .ROM_AW(AW), .REGION_BASE(BASES), .REGION_AW(AWS), .WORD_MODE(1)) u_word (
        .clk_sys(clk), .rst_n(rst_n), .ioctl_download(download), .ioctl_addr(addr), .ioctl_dout(dout),
        .ioctl_wr(wr), .ioctl_wait(w_wait), .rom_wr_en(w_en), .rom_wr_addr(w_addr), .rom_wr_data(w_data),
        .region_done(w_done), .load_done(w_load), .dl_err(w_err), .chk_sel(chk_sel), .chk_sum(w_sum));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: first window containing the address, in index order.
    function automatic int model_region(input longint a);
        for (int i = 0; i < NR; i++)
            if (a >= longint'(m_base[i]) && a < longint'(m_base[i]) + (longint'(1) << m_aw[i])) return i;
        return -1;
    endfunction

    function automatic logic [7:0] model_done();
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < NR; i++) d[i] = (m_cnt[i] == (1 << m_aw[i]));
        return d;
    endfunction

    task automatic model_accept(input int r, input logic [7:0] d);
        if (m_cnt[r] < (1 << m_aw[r])) m_cnt[r] = m_cnt[r] + 1;
        m_sum[r] = (m_sum[r] + int'(d)) & 32'hFFFF;
    endtask

    task automatic start_download;
        download = 1'b0;
        wr = 1'b0;
        tick;
        download = 1'b1;
        tick;
        for (int i = 0; i < NR; i++) begin
            m_cnt[i] = 0;
            m_sum[i] = 0;
        end
    endtask

    task automatic end_download;
        wr = 1'b0;
        download = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        tests_run += 6;
        if (b_en !== 8'h00 || w_en !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL reset_en: got %0h/%0h expected 0", b_en, w_en);
        end
        if (b_addr !== 15'h0 || b_data !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL reset_addr_data: got %0h/%0h expected 0", b_addr, b_data);
        end
        if (b_wait !== 1'b0 || w_wait !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_wait: got %0b/%0b expected 0", b_wait, w_wait);
        end
        if (b_done !== 8'h00 || w_done !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL reset_done: got %0h/%0h expected 0", b_done, w_done);
        end
        if (b_load !== 1'b0 || b_err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_flags: got %0b/%0b expected 0", b_load, b_err);
        end
        if (b_sum !== 16'h0 || w_sum !== 16'h0) begin
            tests_failed++; $display("[TB] FAIL reset_sum: got %0h/%0h expected 0", b_sum, w_sum);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_byte_fill;
        start_download;
        for (int k = 0; k <= 256; k++) begin
            if (k < 256) begin
                addr = 27'h68000 + 27'(k);
                dout = 16'hFF01;
                wr = 1'b1;
            end else begin
                wr = 1'b0;
            end
            tick;
            if (k >= 1) begin
                tests_run++;
                if (b_en !== 8'h01 || b_addr !== 15'(k - 1) || b_data !== 8'h01) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_strobe[%0d]: got en=%0h addr=%0h data=%0h expected en=1 addr=%0h data=1",
                             k - 1, b_en, b_addr, b_data, k - 1);
                end
            end
            if (k == 255) begin
                tests_run++;
                if (b_done !== 8'h00) begin
                    tests_failed++; $display("[TB] FAIL fill_done_early: got %0h expected 0", b_done);
                end
            end
        end
        tick;
        tests_run += 3;
        if (b_en !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL fill_idle_en: got %0h expected 0", b_en);
        end
        if (b_done !== 8'h01) begin
            tests_failed++; $display("[TB] FAIL fill_done: got %0h expected 1", b_done);
        end
        chk_sel = 4'd0;
        #1;
        if (b_sum !== 16'h0100) begin
            tests_failed++; $display("[TB] FAIL fill_sum: got %0h expected 100", b_sum);
        end
        download = 1'b0;
        tick;
        tests_run++;
        if (b_load !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL fill_load_early: got %0b expected 0", b_load);
        end
        tick;
        tests_run++;
        if (b_load !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL fill_load_done: got %0b expected 1", b_load);
        end
    endtask

    task automatic test_window_overlap;
        logic [26:0] addr_tab[4] = '{27'h70000, 27'h2000A, 27'h20010, 27'h13FFF};
        logic [7:0]  en_tab[4]   = '{8'h00, 8'h10, 8'h20, 8'h00};
        logic [14:0] off_tab[4]  = '{15'h0, 15'hA, 15'h8, 15'h0};
        logic [7:0]  d[4];
        start_download;
        for (int k = 0; k < 4; k++) begin
            d[k] = 8'($urandom);
            addr = addr_tab[k];
            dout = {8'h00, d[k]};
            wr = 1'b1;
            tick;
            wr = 1'b0;
            tick;
            tests_run++;
            if (b_en !== en_tab[k] || (en_tab[k] != 8'h00 && (b_addr !== off_tab[k] || b_data !== d[k]))) begin
                tests_failed++;
                $display("[TB] FAIL window[%0d]: got en=%0h addr=%0h data=%0h expected en=%0h addr=%0h data=%0h",
                         k, b_en, b_addr, b_data, en_tab[k], off_tab[k], d[k]);
            end
        end
        tests_run += 4;
        chk_sel = 4'd4; #1;
        if (b_sum !== {8'h00, d[1]}) begin
            tests_failed++; $display("[TB] FAIL overlap_sum4: got %0h expected %0h", b_sum, d[1]);
        end
        chk_sel = 4'd5; #1;
        if (b_sum !== {8'h00, d[2]}) begin
            tests_failed++; $display("[TB] FAIL overlap_sum5: got %0h expected %0h", b_sum, d[2]);
        end
        chk_sel = 4'd1; #1;
        if (b_sum !== 16'h0) begin
            tests_failed++; $display("[TB] FAIL nowin_sum1: got %0h expected 0", b_sum);
        end
        if (b_done !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL nowin_done: got %0h expected 0", b_done);
        end
        end_download;
    endtask

    // Random writes checked cycle by cycle against the model's expected byte slots.
    task automatic test_random_stream(input bit word, input int n);
        logic [7:0]  en_o, data_o, done_o, exp_en, exp_done;
        logic [14:0] addr_o, exp_off;
        logic        wait_o;
        logic [15:0] sum_o;
        longint      a;
        int          r, exp_s;
        bit          prev_wr;
        for (int i = 0; i < 512; i++) begin
            s_valid[i] = 1'b0;
            s_wait[i] = 1'b0;
        end
        start_download;
        prev_wr = 1'b0;
        for (int k = 0; k < n + 3; k++) begin
            if (k < n && !(word && prev_wr) && $urandom_range(0, 99) < 70) begin
                r = $urandom_range(0, 8);
                if (r == 8) a = 64'h70000 + longint'($urandom_range(0, 255));
                else a = longint'(m_base[r]) + longint'($urandom_range(0, (1 << m_aw[r]) + 1));
                addr = 27'(a);
                dout = 16'($urandom);
                wr = 1'b1;
                s_valid[k + 1] = 1'b1;
                s_addr[k + 1] = a;
                s_data[k + 1] = dout[7:0];
                if (word) begin
                    s_valid[k + 2] = 1'b1;
                    s_addr[k + 2] = a + 1;
                    s_data[k + 2] = dout[15:8];
                    s_wait[k + 1] = 1'b1;
                end
                prev_wr = 1'b1;
            end else begin
                wr = 1'b0;
                prev_wr = 1'b0;
            end
            tick;
            en_o   = word ? w_en : b_en;
            addr_o = word ? w_addr : b_addr;
            data_o = word ? w_data : b_data;
            done_o = word ? w_done : b_done;
            wait_o = word ? w_wait : b_wait;
            exp_en = 8'h00;
            exp_off = 15'h0;
            r = s_valid[k] ? model_region(s_addr[k]) : -1;
            if (r >= 0) begin
                exp_en = 8'(1 << r);
                exp_off = 15'((s_addr[k] - longint'(m_base[r])) & 64'h7FFF);
                model_accept(r, s_data[k]);
            end
            exp_done = model_done();
            tests_run++;
            if (en_o !== exp_en || (r >= 0 && (addr_o !== exp_off || data_o !== s_data[k]))) begin
                tests_failed++;
                $display("[TB] FAIL rand_strobe[%0d] word=%0b: got en=%0h addr=%0h data=%0h expected en=%0h addr=%0h data=%0h",
                         k, word, en_o, addr_o, data_o, exp_en, exp_off, s_data[k]);
            end
            tests_run++;
            if (done_o !== exp_done || wait_o !== s_wait[k]) begin
                tests_failed++;
                $display("[TB] FAIL rand_done_wait[%0d] word=%0b: got done=%0h wait=%0b expected done=%0h wait=%0b",
                         k, word, done_o, wait_o, exp_done, s_wait[k]);
            end
        end
        for (int s = 0; s < 16; s++) begin
            chk_sel = 4'(s);
            #1;
            sum_o = word ? w_sum : b_sum;
            exp_s = (s < NR) ? m_sum[s] : 0;
            tests_run++;
            if (sum_o !== 16'(exp_s)) begin
                tests_failed++; $display("[TB] FAIL rand_sum[%0d] word=%0b: got %0h expected %0h", s, word, sum_o, exp_s);
            end
        end
        end_download;
    endtask

    task automatic test_word_basic;
        start_download;
        addr = 27'h14000;
        dout = 16'hBEEF;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tick;
        tests_run++;
        if (w_en !== 8'h02 || w_addr !== 15'h0 || w_data !== 8'hEF || w_wait !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL word_lo: got en=%0h addr=%0h data=%0h wait=%0b expected en=2 addr=0 data=ef wait=1",
                     w_en, w_addr, w_data, w_wait);
        end
        tick;
        tests_run++;
        if (w_en !== 8'h02 || w_addr !== 15'h1 || w_data !== 8'hBE || w_wait !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL word_hi: got en=%0h addr=%0h data=%0h wait=%0b expected en=2 addr=1 data=be wait=0",
                     w_en, w_addr, w_data, w_wait);
        end
        addr = 27'h480FF;
        dout = 16'h5AA5;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tests_run++;
        if (w_en !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL word_gap_en: got %0h expected 0", w_en);
        end
        tick;
        tests_run++;
        if (w_en !== 8'h04 || w_addr !== 15'hFF || w_data !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL straddle_lo: got en=%0h addr=%0h data=%0h expected en=4 addr=ff data=a5", w_en, w_addr, w_data);
        end
        tick;
        tests_run++;
        if (w_en !== 8'h08 || w_addr !== 15'h0 || w_data !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL straddle_hi: got en=%0h addr=%0h data=%0h expected en=8 addr=0 data=5a", w_en, w_addr, w_data);
        end
        tests_run += 2;
        chk_sel = 4'd1; #1;
        if (w_sum !== 16'h01AD) begin
            tests_failed++; $display("[TB] FAIL word_sum1: got %0h expected 1ad", w_sum);
        end
        chk_sel = 4'd3; #1;
        if (w_sum !== 16'h005A) begin
            tests_failed++; $display("[TB] FAIL straddle_sum3: got %0h expected 5a", w_sum);
        end
        end_download;
    endtask

    task automatic test_dl_err;
        start_download;
        addr = 27'h14010;
        dout = 16'h1234;
        wr = 1'b1;
        tick;
        addr = 27'h14020;
        dout = 16'h9999;
        tick;
        wr = 1'b0;
        tests_run++;
        if (w_en !== 8'h02 || w_addr !== 15'h10 || w_data !== 8'h34 || w_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_lo: got en=%0h addr=%0h data=%0h err=%0b expected en=2 addr=10 data=34 err=1",
                     w_en, w_addr, w_data, w_err);
        end
        tick;
        tests_run++;
        if (w_en !== 8'h02 || w_addr !== 15'h11 || w_data !== 8'h12) begin
            tests_failed++;
            $display("[TB] FAIL err_hi: got en=%0h addr=%0h data=%0h expected en=2 addr=11 data=12", w_en, w_addr, w_data);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            tests_run++;
            if (w_en !== 8'h00) begin
                tests_failed++; $display("[TB] FAIL err_dropped[%0d]: got en=%0h expected 0", k, w_en);
            end
        end
        chk_sel = 4'd1; #1;
        tests_run++;
        if (w_sum !== 16'h0046) begin
            tests_failed++; $display("[TB] FAIL err_sum: got %0h expected 46", w_sum);
        end
        end_download;
        tests_run++;
        if (w_err !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL err_sticky: got %0b expected 1", w_err);
        end
        start_download;
        tests_run++;
        if (w_err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL err_clear: got %0b expected 0", w_err);
        end
        end_download;
    endtask

    task automatic test_reset_mid_split;
        start_download;
        addr = 27'h1;
        dout = 16'h0007;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tick;
        tick;
        tick;
        addr = 27'h14000;
        dout = 16'h4321;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        #2;
        rst_n = 1'b0;
        chk_sel = 4'd7;
        #1;
        tests_run++;
        if (w_en !== 8'h00 || w_addr !== 15'h0 || w_data !== 8'h00 || w_wait !== 1'b0 ||
            w_done !== 8'h00 || w_load !== 1'b0 || w_err !== 1'b0 || w_sum !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL split_reset: got en=%0h addr=%0h data=%0h wait=%0b done=%0h load=%0b err=%0b sum=%0h expected all 0",
                     w_en, w_addr, w_data, w_wait, w_done, w_load, w_err, w_sum);
        end
        tick;
        tick;
        tests_run++;
        if (w_en !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL split_reset_hold: got en=%0h expected 0", w_en);
        end
        rst_n = 1'b1;
        start_download;
        addr = 27'h0;
        dout = 16'h0201;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tick;
        tick;
        tests_run += 3;
        if (w_done !== 8'h80) begin
            tests_failed++; $display("[TB] FAIL post_reset_done: got %0h expected 80", w_done);
        end
        chk_sel = 4'd7; #1;
        if (w_sum !== 16'h0003) begin
            tests_failed++; $display("[TB] FAIL post_reset_sum7: got %0h expected 3", w_sum);
        end
        chk_sel = 4'd1; #1;
        if (w_sum !== 16'h0000) begin
            tests_failed++; $display("[TB] FAIL post_reset_sum1: got %0h expected 0", w_sum);
        end
        end_download;
    endtask

    initial begin
        test_reset;
        test_byte_fill;
        test_window_overlap;
        test_random_stream(1'b0, 300);
        test_word_basic;
        test_dl_err;
        test_random_stream(1'b1, 300);
        test_reset_mid_split;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
